// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder.
// SERIAL_ADDER_SUB_EN adds the 'sub' operand-side control bit.
interface serial_adder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    // Operand source / result consumer side
    modport master (
`ifdef SERIAL_ADDER_SUB_EN
        output sub,
`endif
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    // Adder side
    modport slave (
`ifdef SERIAL_ADDER_SUB_EN
        input  sub,
`endif
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus carry flop, LSB first.
// Optional macro SERIAL_ADDER_SUB_EN enables a - b via bus.sub.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [CW-1:0]    count;

    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic             bit_s_c;
    logic             carry_nxt_c;
    logic [WIDTH-1:0] res_nxt_c;
    logic [WIDTH-1:0] b_load_c;
    logic             cin_load_c;

    // Subtract loads ~b with a forced carry-in of one (two's complement)
`ifdef SERIAL_ADDER_SUB_EN
    assign b_load_c   = bus.sub ? ~bus.b : bus.b;
    assign cin_load_c = bus.sub | bus.cin;
`else
    assign b_load_c   = bus.b;
    assign cin_load_c = bus.cin;
`endif

    // The single full-adder cell
    always_comb begin
        bit_s_c     = 1'b0;
        carry_nxt_c = 1'b0;
        bit_s_c     = sa[0] ^ sb[0] ^ carry;
        carry_nxt_c = (sa[0] & sb[0]) | (carry & (sa[0] ^ sb[0]));
    end

    // Result shifts right with the new sum bit entering at the MSB
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_nxt_c = bit_s_c;
        end else begin : g_res_wn
            assign res_nxt_c = {bit_s_c, res[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sa          <= '0;
            sb          <= '0;
            res         <= '0;
            carry       <= 1'b0;
            count       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sa         <= bus.a;
                        sb         <= b_load_c;
                        carry      <= cin_load_c;
                        count      <= '0;
                        res        <= '0;
                        state      <= RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    carry <= carry_nxt_c;
                    res   <= res_nxt_c;
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) begin
                        state       <= DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        sum_q       <= res_nxt_c;
                        cout_q      <= carry_nxt_c;
                    end
                end
                DONE: begin
                    // Hold result until consumed; no same-cycle restart
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: WIDTH=4 instance plus WIDTH=1 instance.
module tb_serial_adder;

    localparam int unsigned W = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    serial_adder_if #(.WIDTH(W)) bus4 ();
    serial_adder_if #(.WIDTH(1)) bus1 ();

    serial_adder #(.WIDTH(W)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
    serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    bit   rand_ready = 1'b0;
    logic [W:0] q4 [$];
    logic [1:0] q1 [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // Reference: plain integer arithmetic on the operands
    function automatic logic [W:0] model4(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic cin, input logic sub);
        int unsigned av = a;
        int unsigned bv = b;
        if (sub) return {(av >= bv), W'(av - bv)};
        return (W+1)'(av + bv + 32'(cin));
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus4.out_valid && bus4.out_ready) begin
            if (q4.size() == 0) fail("q4_unexpected_result");
            else begin
                logic [W:0] e;
                e = q4.pop_front();
                chk("sum4", 32'(bus4.sum), 32'(e[W-1:0]));
                chk("cout4", 32'(bus4.cout), 32'(e[W]));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus1.out_valid && bus1.out_ready) begin
            if (q1.size() == 0) fail("q1_unexpected_result");
            else begin
                logic [1:0] e;
                e = q1.pop_front();
                chk("sum1", 32'(bus1.sum), 32'(e[0]));
                chk("cout1", 32'(bus1.cout), 32'(e[1]));
            end
        end
    end

    // Random consumer backpressure
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) bus4.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Returns #1 after the accepting edge
    task automatic send4(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub);
        int n = 0;
        @(posedge clk);
        #1;
        while (!bus4.in_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus4.in_ready) begin
            fail("accept4_timeout");
            return;
        end
        bus4.in_valid = 1'b1;
        bus4.a        = a;
        bus4.b        = b;
        bus4.cin      = cin;
`ifdef SERIAL_ADDER_SUB_EN
        bus4.sub      = sub;
`endif
        @(posedge clk);
        #1;
        bus4.in_valid = 1'b0;
        bus4.a        = W'($urandom);
        bus4.b        = W'($urandom);
        bus4.cin      = 1'($urandom);
        q4.push_back(model4(a, b, cin, sub));
    endtask

    task automatic drain4();
        int n = 0;
        while (q4.size() != 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (q4.size() != 0) fail("drain4_timeout");
    endtask

    task automatic drain1();
        int n = 0;
        while (q1.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (q1.size() != 0) fail("drain1_timeout");
    endtask

    initial begin
        int lat;
        int nbusy;
        int n;
        logic sub_r;

        bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0; bus4.out_ready = 1'b1;
        bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.out_ready = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
        bus4.sub = 1'b0;
        bus1.sub = 1'b0;
`endif
        sub_r = 1'b0;

        #12;
        chk("rst_in_ready", 32'(bus4.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus4.out_valid), 32'd0);
        chk("rst_busy", 32'(bus4.busy), 32'd0);
        chk("rst_sum", 32'(bus4.sum), 32'd0);
        chk("rst_cout", 32'(bus4.cout), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Latency and busy duration
        send4(4'd3, 4'd5, 1'b0, 1'b0);
        lat = 0;
        nbusy = 0;
        while (!bus4.out_valid && lat < 50) begin
            if (bus4.busy) nbusy++;
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(W));
        chk("busy_cycles", 32'(nbusy), 32'(W));
        chk("sum_3_5", 32'(bus4.sum), 32'd8);
        drain4();

        send4(4'd15, 4'd1, 1'b0, 1'b0);
        send4(4'd15, 4'd15, 1'b1, 1'b0);
        drain4();

        // Backpressure hold
        bus4.out_ready = 1'b0;
        send4(4'd6, 4'd7, 1'b0, 1'b0);
        n = 0;
        while (!bus4.out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus4.out_valid) fail("bp_out_valid_timeout");
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp_out_valid", 32'(bus4.out_valid), 32'd1);
            chk("bp_sum", 32'(bus4.sum), 32'd13);
            chk("bp_cout", 32'(bus4.cout), 32'd0);
            chk("bp_in_ready", 32'(bus4.in_ready), 32'd0);
        end
        bus4.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_out_valid", 32'(bus4.out_valid), 32'd0);
        chk("bp_release_in_ready", 32'(bus4.in_ready), 32'd1);
        drain4();

        // Asynchronous reset two cycles into RUN
        send4(4'd9, 4'd12, 1'b1, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(bus4.busy), 32'd0);
        chk("arst_in_ready", 32'(bus4.in_ready), 32'd1);
        chk("arst_out_valid", 32'(bus4.out_valid), 32'd0);
        chk("arst_sum", 32'(bus4.sum), 32'd0);
        chk("arst_cout", 32'(bus4.cout), 32'd0);
        q4.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send4(4'd2, 4'd2, 1'b0, 1'b0);
        drain4();

`ifdef SERIAL_ADDER_SUB_EN
        send4(4'd5, 4'd3, 1'b0, 1'b1);
        send4(4'd3, 4'd5, 1'b0, 1'b1);
        drain4();
`endif

        // Random operands with random consumer stalls
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
`ifdef SERIAL_ADDER_SUB_EN
            sub_r = 1'($urandom);
`endif
            send4(W'($urandom), W'($urandom), 1'($urandom), sub_r);
        end
        rand_ready = 1'b0;
        bus4.out_ready = 1'b1;
        drain4();

        // WIDTH=1 full-adder truth table
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            n = 0;
            @(posedge clk);
            #1;
            while (!bus1.in_ready && n < 50) begin
                @(posedge clk);
                #1;
                n++;
            end
            if (!bus1.in_ready) fail("accept1_timeout");
            else begin
                bus1.in_valid = 1'b1;
                bus1.a        = v[2];
                bus1.b        = v[1];
                bus1.cin      = v[0];
                @(posedge clk);
                #1;
                bus1.in_valid = 1'b0;
                q1.push_back(2'(32'(v[2]) + 32'(v[1]) + 32'(v[0])));
                chk("w1_busy", 32'(bus1.busy), 32'd1);
                @(posedge clk);
                #1;
                chk("w1_out_valid", 32'(bus1.out_valid), 32'd1);
            end
        end
        drain1();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
